alu_seq_multiplier: RTL and testbench
=====================================

# alu_seq_multiplier

Sequential, parametrised shift-add multiplier for the ALU arithmetic group. It produces a full 2×WIDTH product over WIDTH clock cycles and supports both unsigned and two's-complement signed operands. Operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake. It replaces the single-cycle combinational multiplier wherever area or timing matters more than latency.

## Interface
- WIDTH, 8, operand bit width; legal range 2 to 64.
- clk  input  1  clock, all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- in1  input  WIDTH  multiplicand.
- in2  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  output  1  product available; high only in DONE.
- out_ready  input  1  consumer takes the product.
- out_low  output  WIDTH  product bits [WIDTH-1:0].
- out_high  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- busy  output  1  high in RUN and DONE.

## Operation
- State machine with three states: IDLE, RUN, DONE.
  - IDLE→RUN when in_valid && in_ready.
  - RUN→DONE on the WIDTH-th RUN edge.
  - DONE→IDLE when out_valid && out_ready.
  - No other transitions.
- On accept, the block registers the operands, the mode, and neg = is_signed & (in1[MSB] ^ in2[MSB]).
  - Signed mode: it stores |in1| and |in2| as WIDTH-bit unsigned values. |−2^(WIDTH−1)| = 2^(WIDTH−1) is still representable unsigned.
  - Unsigned mode: it stores the operands unchanged.
  - Acceptance clears the 2×WIDTH accumulator and the step counter. The counter is $clog2(WIDTH+1) bits.
- Each RUN edge performs one step:
  - If multiplier bit[0] = 1, add the multiplicand into the upper half of the accumulator. The add is WIDTH+1 bits wide so the carry is kept.
  - Shift the accumulator and the carry right by 1.
  - Shift the multiplier right by 1.
  - Increment the counter.
- On the final RUN edge, the product is negated (two's complement, 2×WIDTH bits) if neg = 1, then loaded into the output registers.
- Operands, mode, in_valid and out_ready have no effect outside the cycles in which they are sampled. Input changes during RUN or DONE are ignored.
- Arithmetic wraps modulo 2^(2×WIDTH); no overflow is possible.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_low = 0, out_high = 0, accumulator and counter = 0.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: one product per WIDTH+2 cycles at best. The accept cycle, the WIDTH RUN edges and the DONE handshake cycle do not overlap.
- Back-pressure: while out_valid = 1 and out_ready = 0, out_low and out_high stay stable and in_ready stays 0.
- in_ready = 0 in the cycle in which the output handshake completes. The next accept is possible one cycle later.
- in_valid with in_ready = 0 is ignored; the block does not queue it.
- Reset asserted mid-RUN or mid-DONE: all registers return to reset values immediately, without waiting for a clock edge. The in-flight product is discarded.
- All outputs are driven from registers. There is no combinational path from inputs to outputs.

## Structure
- Shared package alu_mult_pkg holds:
  - the state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - mode constants MODE_UNSIGNED = 1'b0 and MODE_SIGNED = 1'b1.
- One sub-module, mult_step: combinational single shift-add step.
  - Inputs: accumulator, multiplicand, multiplier bit.
  - Output: next accumulator.
  - Parametrised by WIDTH.
- The top level holds the FSM, operand registers, counter, sign fix-up and output registers.

## Test plan
- WIDTH=4, unsigned 15×15 → out_high=0xE, out_low=0x1, with out_valid exactly 4 edges after accept.
- WIDTH=4, signed −8×−8 → out_high=0x4, out_low=0x0. Signed −8×1 → out_high=0xF, out_low=0x8.
- WIDTH=4, signed 3×−5 → out_high=0xF, out_low=0x1. The same bits presented unsigned (3×11) → out_high=0x2, out_low=0x1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. Required:
  - out_low, out_high and out_valid stay stable;
  - in_ready stays 0;
  - in_valid pulses during this time are dropped;
  - out_ready=1 gives IDLE on the next edge.
- Operand change mid-RUN: change in1, in2 and is_signed every cycle during RUN → result still matches the values captured at accept.
- Reset mid-operation: assert rst_n=0 on the 2nd RUN cycle. Required:
  - all outputs go to their reset values with no clock edge;
  - after release, WIDTH=8 unsigned 200×100 gives out_high=0x4E, out_low=0x20.

Source files
------------

// File: rtl/alu_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the controller state encoding and operand mode constants.
package alu_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mult_step.sv
// One combinational shift-add step: conditionally add the multiplicand into the
// upper accumulator half (keeping the carry) and shift the whole thing right by one.
module mult_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               mbit,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] addend_s;
    logic [WIDTH:0] sum_s;

    // Carry bit of the add becomes the new MSB after the right shift.
    always_comb begin
        addend_s = {(WIDTH+1){1'b0}};
        if (mbit) begin
            addend_s = {1'b0, mcand};
        end else begin
            addend_s = {(WIDTH+1){1'b0}};
        end
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend_s;
        acc_next = {sum_s, acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/alu_seq_multiplier.sv
// Sequential WIDTH-cycle shift-add multiplier with signed/unsigned operands,
// valid/ready handshakes on both sides and fully registered outputs.
module alu_seq_multiplier
    import alu_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_low,
    output logic [WIDTH-1:0] out_high,
    output logic             busy
);

    localparam int                 CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   W_ONE    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] P_ONE    = (2*WIDTH)'(1);

    mult_state_t          state_r, next_state_s;
    logic [WIDTH-1:0]     mcand_r, mplier_r;
    logic [2*WIDTH-1:0]   acc_r, acc_next_s, prod_s;
    logic [CW-1:0]        cnt_r;
    logic                 mode_r, sign_xor_r;
    logic                 accept_s, last_step_s, neg_s;
    logic                 in_ready_r, out_valid_r, busy_r;
    logic [WIDTH-1:0]     out_low_r, out_high_r;

    // In signed mode the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return ~v + W_ONE;
        end else begin
            return v;
        end
    endfunction

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_r),
        .mcand    (mcand_r),
        .mbit     (mplier_r[0]),
        .acc_next (acc_next_s)
    );

    // Controller next-state decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_step_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    next_state_s = RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = DONE;
                    last_step_s  = 1'b1;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Sign fix-up applied to the finished magnitude product.
    always_comb begin
        neg_s  = (mode_r == MODE_SIGNED) && sign_xor_r;
        prod_s = acc_next_s;
        if (neg_s) begin
            prod_s = ~acc_next_s + P_ONE;
        end else begin
            prod_s = acc_next_s;
        end
    end

    // State register and handshake/status flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == IDLE);
            out_valid_r <= (next_state_s == DONE);
            busy_r      <= (next_state_s != IDLE);
        end
    end

    // Operand capture, iterative accumulate and result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r    <= {WIDTH{1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            cnt_r      <= {CW{1'b0}};
            mode_r     <= MODE_UNSIGNED;
            sign_xor_r <= 1'b0;
            out_low_r  <= {WIDTH{1'b0}};
            out_high_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            mcand_r    <= magnitude(in1, is_signed);
            mplier_r   <= magnitude(in2, is_signed);
            acc_r      <= {(2*WIDTH){1'b0}};
            cnt_r      <= {CW{1'b0}};
            mode_r     <= is_signed;
            sign_xor_r <= in1[WIDTH-1] ^ in2[WIDTH-1];
        end else if (state_r == RUN) begin
            acc_r    <= acc_next_s;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_ONE;
            if (last_step_s) begin
                out_low_r  <= prod_s[WIDTH-1:0];
                out_high_r <= prod_s[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_low   = out_low_r;
    assign out_high  = out_high_r;

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed bench for alu_seq_multiplier: one WIDTH=4 and one WIDTH=8 instance
// sharing clock and reset, with hand-computed products.
module tb_alu_seq_multiplier;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid4 = 1'b0, in_ready4, sgn4 = 1'b0, out_valid4, out_ready4 = 1'b0, busy4;
    logic [3:0] in1_4 = 4'd0, in2_4 = 4'd0, out_low4, out_high4;

    logic       in_valid8 = 1'b0, in_ready8, sgn8 = 1'b0, out_valid8, out_ready8 = 1'b0, busy8;
    logic [7:0] in1_8 = 8'd0, in2_8 = 8'd0, out_low8, out_high8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in1(in1_4), .in2(in2_4), .is_signed(sgn4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_low(out_low4), .out_high(out_high4), .busy(busy4)
    );

    alu_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in1(in1_8), .in2(in2_8), .is_signed(sgn8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_low(out_low8), .out_high(out_high8), .busy(busy8)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // WIDTH=4 transaction: optional operand scrambling during RUN and back-pressure hold.
    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [7:0] exp, input bit scramble, input int hold);
        int n;
        logic [7:0] held;
        @(negedge clk);
        in1_4 = a; in2_4 = b; sgn4 = s; in_valid4 = 1'b1;
        check_eq({tag, "_rdy"}, 16'(in_ready4), 16'd1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 40) begin
            if (scramble) begin
                in1_4 = 4'($urandom); in2_4 = 4'($urandom); sgn4 = 1'($urandom); in_valid4 = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid4 = 1'b0;
        check_eq({tag, "_lat"}, 16'(n), 16'd4);
        check_eq({tag, "_prod"}, 16'({out_high4, out_low4}), 16'(exp));
        check_eq({tag, "_rdy_done"}, 16'(in_ready4), 16'd0);
        held = {out_high4, out_low4};
        for (int i = 0; i < hold; i++) begin
            in_valid4 = 1'(i % 2);
            in1_4 = 4'd7; in2_4 = 4'd7;
            @(posedge clk); #1;
            check_eq({tag, "_bp_valid"}, 16'(out_valid4), 16'd1);
            check_eq({tag, "_bp_prod"}, 16'({out_high4, out_low4}), 16'(held));
            check_eq({tag, "_bp_rdy"}, 16'(in_ready4), 16'd0);
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check_eq({tag, "_idle_valid"}, 16'(out_valid4), 16'd0);
        check_eq({tag, "_idle_rdy"}, 16'(in_ready4), 16'd1);
        check_eq({tag, "_idle_busy"}, 16'(busy4), 16'd0);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp);
        int n;
        @(negedge clk);
        in1_8 = a; in2_8 = b; sgn8 = s; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_lat"}, 16'(n), 16'd8);
        check_eq({tag, "_prod"}, {out_high8, out_low8}, exp);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check_eq({tag, "_idle_rdy"}, 16'(in_ready8), 16'd1);
    endtask

    initial begin
        #12;
        check_eq("rst_rdy", 16'(in_ready4), 16'd1);
        check_eq("rst_valid", 16'(out_valid4), 16'd0);
        check_eq("rst_busy", 16'(busy4), 16'd0);
        check_eq("rst_prod", 16'({out_high4, out_low4}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run4("u15x15", 4'hF, 4'hF, 1'b0, 8'hE1, 1'b0, 0);
        run4("sm8xm8", 4'h8, 4'h8, 1'b1, 8'h40, 1'b0, 0);
        run4("sm8x1", 4'h8, 4'h1, 1'b1, 8'hF8, 1'b0, 0);
        run4("s3xm5", 4'h3, 4'hB, 1'b1, 8'hF1, 1'b0, 0);
        run4("bp", 4'h5, 4'h6, 1'b0, 8'h1E, 1'b0, 10);
        run4("scr", 4'hD, 4'h7, 1'b1, 8'hEB, 1'b1, 0);
        run4("u3x11", 4'h3, 4'hB, 1'b0, 8'h21, 1'b0, 0);

        // Reset in the second RUN cycle of dut8; dut4 still holds 0x21 from above.
        @(negedge clk);
        in1_8 = 8'd13; in2_8 = 8'd11; sgn8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_busy", 16'(busy8), 16'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 16'(busy8), 16'd0);
        check_eq("mid_rst_rdy", 16'(in_ready8), 16'd1);
        check_eq("mid_rst_valid", 16'(out_valid8), 16'd0);
        check_eq("mid_rst_prod8", {out_high8, out_low8}, 16'd0);
        check_eq("mid_rst_prod4", 16'({out_high4, out_low4}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8("u200x100", 8'd200, 8'd100, 1'b0, 16'h4E20);
        run8("s127xm1", 8'h7F, 8'hFF, 1'b1, 16'hFF81);
        run8("sm128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
